// File: rtl/led_blink_seq.sv
// ============================================================================
// Module      : led_blink_seq
// Description : Command-driven LED blink sequencer. It accepts one command of
//               blink count plus on/off durations and performs exactly that
//               many on/off cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module led_blink_seq #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int CNT_W    = 8,
    parameter int DUR_W    = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [CNT_W-1:0] cmd_count_i,
    input  logic [DUR_W-1:0] cmd_on_ms_i,
    input  logic [DUR_W-1:0] cmd_off_ms_i,
    output logic             led_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PS_W     = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    state_e             state_q;
    logic               led_q;
    logic               busy_q;
    logic               done_q;
    logic [PS_W-1:0]    ps_q;
    logic [DUR_W-1:0]   tick_q;
    logic [CNT_W-1:0]   rem_q;
    logic [DUR_W-1:0]   on_last_q;
    logic [DUR_W-1:0]   off_last_q;

    logic               w_accept;
    logic [DUR_W-1:0]   w_on_last_d;
    logic [DUR_W-1:0]   w_off_last_d;
    logic [DUR_W-1:0]   w_phase_last;

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign w_accept    = cmd_valid_i && cmd_ready_o;

    // Durations are stored as (ticks - 1); a zero field collapses to one tick.
    assign w_on_last_d  = (cmd_on_ms_i  == '0) ? '0 : cmd_on_ms_i  - DUR_W'(1);
    assign w_off_last_d = (cmd_off_ms_i == '0) ? '0 : cmd_off_ms_i - DUR_W'(1);
    assign w_phase_last = (state_q == ST_ON) ? on_last_q : off_last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ps_q       <= '0;
            tick_q     <= '0;
            rem_q      <= '0;
            on_last_q  <= '0;
            off_last_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        on_last_q  <= w_on_last_d;
                        off_last_q <= w_off_last_d;
                        ps_q       <= '0;
                        tick_q     <= '0;
                        rem_q      <= cmd_count_i;
                        if (cmd_count_i != '0) begin
                            state_q <= ST_ON;
                            led_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_ON, ST_OFF: begin
                    if (ps_q != PS_LAST) begin
                        ps_q <= ps_q + PS_W'(1);
                    end else begin
                        ps_q <= '0;
                        if (tick_q != w_phase_last) begin
                            tick_q <= tick_q + DUR_W'(1);
                        end else begin
                            tick_q <= '0;
                            if (state_q == ST_OFF) begin
                                state_q <= ST_ON;
                                led_q   <= 1'b1;
                            end else begin
                                rem_q <= rem_q - CNT_W'(1);
                                led_q <= 1'b0;
                                // Last blink skips the trailing OFF phase.
                                if (rem_q == CNT_W'(1)) begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_OFF;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: doc/led_blink_seq.md
Name: led_blink_seq

Overview:
Command-driven LED blink sequencer. Accepts a blink command with a count and on/off durations in milliseconds over a valid/ready handshake. Drives a single LED through exactly that many on/off cycles, then signals completion. Sits between board-level status logic and an LED pin, replacing free-running toggle counters so several status sources can schedule LED activity deterministically.

Parameters:
CLK_FREQ, 100_000_000, input clock frequency in Hz
TICK_HZ, 1000, timebase rate; 1000 gives 1 ms units; TICK_DIV = CLK_FREQ / TICK_HZ, must be >= 2
CNT_W, 8, width of blink count field
DUR_W, 12, width of on/off duration fields, in ticks

Ports:
clk_i  input  1  system clock, single clock domain
rst_i  input  1  synchronous, active-high reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  block can accept a command
cmd_count_i  input  CNT_W  number of blinks
cmd_on_ms_i  input  DUR_W  LED-on duration per blink, in ticks
cmd_off_ms_i  input  DUR_W  LED-off duration between blinks, in ticks
led_o  output  1  LED drive, registered, 1 = lit
busy_o  output  1  sequence in progress
done_o  output  1  one-cycle pulse when a sequence finishes

Behaviour:
- Clocking: one clock, clk_i. rst_i is synchronous and active-high, sampled on posedge clk_i.
- Reset values: state=IDLE, led_o=0, busy_o=0, done_o=0, cmd_ready_o=1, prescaler=0, tick counter=0, remaining count=0.
- Handshake:
  - cmd_ready_o = 1 only in IDLE, and is a combinational decode of state.
  - A command is accepted on a cycle with cmd_valid_i && cmd_ready_o.
  - On accept, all three fields are latched. Inputs are ignored at all other times.
  - No queueing: cmd_valid_i held while busy waits until ready.
- Duration rule: a duration field of 0 is treated as 1 tick.
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits an internal tick when it equals TICK_DIV-1.
  - Cleared to 0 on accept and on every phase change, so each phase is exactly an integer number of ticks.
  - Inactive in IDLE.
- FSM states: IDLE, ON, OFF.
  - IDLE, accept, count != 0: go to ON. Next cycle led_o=1, busy_o=1, remaining=count.
  - IDLE, accept, count == 0: stay in IDLE, led_o stays 0. Next cycle done_o=1 for one cycle; busy_o never asserts.
  - ON: led_o=1. After on_ms ticks (on_ms*TICK_DIV cycles), decrement remaining.
    - If remaining was 1: go to IDLE, led_o=0, done_o=1 for that cycle. The trailing OFF phase is skipped.
    - Otherwise: go to OFF, led_o=0.
  - OFF: led_o=0. After off_ms ticks, go to ON, led_o=1.
- Latency:
  - Accept to led_o rising: 1 cycle.
  - Each ON phase: exactly on_ms*TICK_DIV cycles.
  - Each OFF phase: exactly off_ms*TICK_DIV cycles.
  - Total busy time: count*on*TICK_DIV + (count-1)*off*TICK_DIV cycles.
- busy_o = (state != IDLE), registered together with the state.
- done_o asserts in the same cycle that busy_o falls.
- Back-to-back commands: cmd_ready_o returns in the cycle done_o pulses. A command accepted then starts ON on the next cycle, with no idle gap. done_o is not repeated.
- Reset mid-sequence: the next cycle shows all reset values. No done_o is produced for the aborted sequence.
- Widths:
  - Tick counter is DUR_W bits and compares against duration-1.
  - Remaining count is CNT_W bits.
  - The maximum count (all ones) must not wrap.
  - Prescaler width is clog2(TICK_DIV).

Test Plan:
(All runs use CLK_FREQ=1000, TICK_HZ=100, so TICK_DIV=10.)
1. Reset, then idle 20 cycles -> led_o=0, busy_o=0, done_o=0, cmd_ready_o=1 throughout.
2. Accept count=3, on=2, off=1 -> led_o pattern is 20 high, 10 low, 20 high, 10 low, 20 high. Then done_o pulses once, busy_o is high for exactly 80 cycles, and cmd_ready_o=0 throughout.
3. Accept count=0 -> done_o high exactly 1 cycle after accept; led_o and busy_o stay 0.
4. Accept count=1, on=0, off=0 -> led_o high 10 cycles, then done_o; no OFF phase.
5. Hold cmd_valid_i high with two different commands, the second changed while busy -> second accepted in the done_o cycle, using its own fields. led_o rises the next cycle with no gap, and the first command's fields are unaffected by input changes mid-sequence.
6. Assert rst_i for 1 cycle mid-ON of count=5, on=4, off=4 -> next cycle led_o=0, busy_o=0, cmd_ready_o=1. No done_o; a new command is then accepted normally.
